// File: rtl/crossbar_bus_pkg.sv
// Purpose : shared types for the crossbar (opcodes, FSM states, index check).
// Latency : n/a (types only).
// Backpr. : n/a.
package crossbar_bus_pkg;

`include "crossbar_defs.vh"

    typedef enum logic [1:0] {
        OP_CONNECT    = `CB_OP_CONNECT,
        OP_DISCONNECT = `CB_OP_DISCONNECT,
        OP_CLEAR      = `CB_OP_CLEAR,
        OP_COMMIT     = `CB_OP_COMMIT
    } cb_op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } cb_state_e;

    // Index range check; only ever false when IN/OUT are not powers of two.
    function automatic logic idx_ok(input int unsigned idx, input int unsigned limit);
        return idx < limit;
    endfunction

endpackage

// File: rtl/crossbar_bus_if.sv
// Purpose : lane buses plus valid/ready config port of the crossbar.
// Latency : n/a (wiring only).
// Backpr. : cfg_ready low while a CLEAR sweep runs; master holds the command.
// Ports   : in/out packed lanes, cfg_valid/ready/op/out/in, cfg_err, pending.
interface crossbar_bus_if #(
    parameter int LW  = 8,
    parameter int IN  = 8,
    parameter int OUT = 8
);
    localparam int IW = $clog2(IN);
    localparam int OW = $clog2(OUT);

    logic [IN*LW-1:0]  in;
    logic [OUT*LW-1:0] out;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [1:0]        cfg_op;
    logic [OW-1:0]     cfg_out;
    logic [IW-1:0]     cfg_in;
    logic              cfg_err;
    logic              pending;

    modport master (
        output in, cfg_valid, cfg_op, cfg_out, cfg_in,
        input  out, cfg_ready, cfg_err, pending
    );

    modport slave (
        input  in, cfg_valid, cfg_op, cfg_out, cfg_in,
        output out, cfg_ready, cfg_err, pending
    );

endinterface

// File: rtl/crossbar_defs.vh
// Opcode encodings for the crossbar configuration port.
// Shared between RTL and anything else that needs to build commands.
`ifndef CROSSBAR_DEFS_VH
`define CROSSBAR_DEFS_VH

`define CB_OP_CONNECT    2'd0
`define CB_OP_DISCONNECT 2'd1
`define CB_OP_CLEAR      2'd2
`define CB_OP_COMMIT     2'd3

`endif

// File: rtl/crossbar_lane.sv
// Purpose : one output lane: active routing entry plus registered LW-bit mux.
// Latency : 1 cycle from in_i to out_o; active entry loads on load_i.
// Backpr. : none; lane always updates.
// Ports   : clock, reset (sync, high), in_i bus, load_i, en_d_i, sel_d_i, out_o.
module crossbar_lane #(
    parameter int LW = 8,
    parameter int IN = 8,
    parameter int IW = $clog2(IN)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [IN*LW-1:0]  in_i,
    input  logic              load_i,
    input  logic              en_d_i,
    input  logic [IW-1:0]     sel_d_i,
    output logic [LW-1:0]     out_o
);

    logic          en_q;
    logic [IW-1:0] sel_q;
    logic [LW-1:0] out_q;
    logic [LW-1:0] out_d;

    // Disabled entry drives zero; the selector never holds an index >= IN.
    always_comb begin
        out_d = '0;
        for (int k = 0; k < IN; k++) begin
            if (en_q && (sel_q == IW'(k))) begin
                out_d = in_i[k*LW +: LW];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            en_q  <= 1'b0;
            sel_q <= '0;
            out_q <= '0;
        end else begin
            if (load_i) begin
                en_q  <= en_d_i;
                sel_q <= sel_d_i;
            end
            out_q <= out_d;
        end
    end

    assign out_o = out_q;

endmodule

// File: rtl/crossbar_bus.sv
// Purpose : single-source-per-output crossbar with shadow/active routing tables.
// Latency : out is registered, 1 cycle; COMMIT at edge N shows on out at N+1.
// Backpr. : cfg_ready drops for exactly OUT cycles during a CLEAR_ALL sweep.
// Ports   : clock, reset (sync, high), bus (crossbar_bus_if.slave).
module crossbar_bus
    import crossbar_bus_pkg::*;
#(
    parameter int LW  = 8,
    parameter int IN  = 8,
    parameter int OUT = 8
) (
    input  logic           clock,
    input  logic           reset,
    crossbar_bus_if.slave  bus
);

    localparam int IW = $clog2(IN);
    localparam int OW = $clog2(OUT);

    logic          shadow_en_q  [OUT];
    logic          shadow_en_d  [OUT];
    logic [IW-1:0] shadow_sel_q [OUT];
    logic [IW-1:0] shadow_sel_d [OUT];

    cb_state_e     state_q, state_d;
    logic [OW-1:0] clr_idx_q, clr_idx_d;
    logic          pending_q, pending_d;
    logic          cfg_err_q, cfg_err_d;
    logic          commit;
    logic          accept;
    logic          out_ok;
    logic          in_ok;

    assign accept = bus.cfg_valid && (state_q == ST_IDLE);
    assign out_ok = idx_ok(32'(bus.cfg_out), OUT);
    assign in_ok  = idx_ok(32'(bus.cfg_in), IN);

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        pending_d = pending_q;
        cfg_err_d = 1'b0;
        commit    = 1'b0;
        for (int j = 0; j < OUT; j++) begin
            shadow_en_d[j]  = shadow_en_q[j];
            shadow_sel_d[j] = shadow_sel_q[j];
        end

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    unique case (cb_op_e'(bus.cfg_op))
                        OP_CONNECT: begin
                            if (out_ok && in_ok) begin
                                for (int j = 0; j < OUT; j++) begin
                                    if (OW'(j) == bus.cfg_out) begin
                                        shadow_en_d[j]  = 1'b1;
                                        shadow_sel_d[j] = bus.cfg_in;
                                    end
                                end
                                pending_d = 1'b1;
                            end else begin
                                cfg_err_d = 1'b1;
                            end
                        end
                        OP_DISCONNECT: begin
                            if (out_ok) begin
                                for (int j = 0; j < OUT; j++) begin
                                    if (OW'(j) == bus.cfg_out) begin
                                        shadow_en_d[j] = 1'b0;
                                    end
                                end
                                pending_d = 1'b1;
                            end else begin
                                cfg_err_d = 1'b1;
                            end
                        end
                        OP_CLEAR: begin
                            state_d   = ST_CLEAR;
                            clr_idx_d = '0;
                            pending_d = 1'b1;
                        end
                        OP_COMMIT: begin
                            // Lanes copy the current shadow table this edge.
                            commit    = 1'b1;
                            pending_d = 1'b0;
                        end
                    endcase
                end
            end
            ST_CLEAR: begin
                // One entry per cycle; last entry returns to IDLE, so the
                // port is busy for exactly OUT cycles.
                for (int j = 0; j < OUT; j++) begin
                    if (OW'(j) == clr_idx_q) begin
                        shadow_en_d[j]  = 1'b0;
                        shadow_sel_d[j] = '0;
                    end
                end
                if (clr_idx_q == OW'(OUT - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    clr_idx_d = clr_idx_q + 1'b1;
                end
            end
        endcase
    end

    // Reset also clears the shadow table, so a reset mid-sweep leaves
    // nothing half-cleared.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            clr_idx_q <= '0;
            pending_q <= 1'b0;
            cfg_err_q <= 1'b0;
            for (int j = 0; j < OUT; j++) begin
                shadow_en_q[j]  <= 1'b0;
                shadow_sel_q[j] <= '0;
            end
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            pending_q <= pending_d;
            cfg_err_q <= cfg_err_d;
            for (int j = 0; j < OUT; j++) begin
                shadow_en_q[j]  <= shadow_en_d[j];
                shadow_sel_q[j] <= shadow_sel_d[j];
            end
        end
    end

    assign bus.cfg_ready = (state_q == ST_IDLE);
    assign bus.cfg_err   = cfg_err_q;
    assign bus.pending   = pending_q;

    for (genvar j = 0; j < OUT; j++) begin : g_lane
        logic [LW-1:0] lane_out;

        crossbar_lane #(
            .LW (LW),
            .IN (IN),
            .IW (IW)
        ) u_lane (
            .clock   (clock),
            .reset   (reset),
            .in_i    (bus.in),
            .load_i  (commit),
            .en_d_i  (shadow_en_q[j]),
            .sel_d_i (shadow_sel_q[j]),
            .out_o   (lane_out)
        );

        assign bus.out[j*LW +: LW] = lane_out;
    end

endmodule
